// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LOAD   = 3'd2,
      S_START  = 3'd3,
      S_DATA   = 3'd4,
      S_PARITY = 3'd5,
      S_STOP   = 3'd6
   } state_t;

   localparam int DATA_BITS            = 8;
   localparam int CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear || count == LAST)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and serialises them as UART frames.
//  state  | meaning
//  IDLE   | line at mark, waiting for tx_en and a non-empty FIFO
//  FETCH  | one-cycle FIFO pop
//  LOAD   | FIFO data captured into the shift register
//  START  | start bit (low)
//  DATA   | eight data bits, LSB first
//  PARITY | even parity bit (only when enabled)
//  STOP   | one or two stop bits (high)
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter bit PARITY_EN    = 1'b0,
   parameter int STOP_BITS    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_data,
   output logic        fifo_rd_en,
   input  logic        tx_en,
   output logic        tx,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frames_sent
);

   state_t     state, state_nxt;
   logic [7:0] shift;
   logic [2:0] bit_idx;
   logic       parity;
   logic       tick;
   logic       last_data;
   logic       last_stop;

   assign last_data = (bit_idx == 3'(DATA_BITS - 1));
   assign last_stop = (bit_idx == 3'(STOP_BITS - 1));

   uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (state_nxt != state),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      tx         = 1'b1;
      fifo_rd_en = 1'b0;
      busy       = (state != S_IDLE);
      frame_done = 1'b0;
      case (state)
         S_IDLE:   if (tx_en && !fifo_empty) state_nxt = S_FETCH;
         S_FETCH: begin
            fifo_rd_en = 1'b1;
            state_nxt  = S_LOAD;
         end
         S_LOAD:   state_nxt = S_START;
         S_START: begin
            tx = 1'b0;
            if (tick) state_nxt = S_DATA;
         end
         S_DATA: begin
            tx = shift[0];
            if (tick && last_data) state_nxt = PARITY_EN ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            tx = parity;
            if (tick) state_nxt = S_STOP;
         end
         S_STOP: begin
            if (tick && last_stop) begin
               frame_done = 1'b1;
               state_nxt  = S_IDLE;
            end
         end
         default:  state_nxt = S_IDLE;
      endcase
   end

   // bit_idx wraps to 0 after D7 and is then reused to count stop bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift       <= '0;
         bit_idx     <= '0;
         parity      <= 1'b0;
         frames_sent <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               shift   <= fifo_data;
               bit_idx <= '0;
               parity  <= 1'b0;
            end
            S_DATA: begin
               if (tick) begin
                  shift   <= {1'b0, shift[7:1]};
                  parity  <= parity ^ shift[0];
                  bit_idx <= bit_idx + 1'b1;
               end
            end
            S_STOP: begin
               if (tick) bit_idx <= bit_idx + 1'b1;
               if (frame_done) frames_sent <= frames_sent + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: two transmitters (8N1 and 8E2, 4 clk/bit) fed by a behavioural FIFO,
// each watched by a line receiver comparing against expected frames built from the queued bytes.
module tb_fifo_uart_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_en[2]       = '{1'b0, 1'b0};
   logic        fifo_empty[2]  = '{1'b1, 1'b1};
   logic [7:0]  fifo_data[2]   = '{8'h00, 8'h00};
   logic        fifo_rd_en[2];
   logic        tx[2];
   logic        busy[2];
   logic        frame_done[2];
   logic [15:0] frames_sent[2];

   logic [7:0]  fmem[2][256];
   logic [7:0]  fwr[2] = '{8'd0, 8'd0};
   logic [7:0]  frd[2] = '{8'd0, 8'd0};
   int          rd_cnt[2]  = '{0, 0};
   int          rd_viol[2] = '{0, 0};
   logic [7:0]  exp_mem[2][256];
   logic [7:0]  ewr[2] = '{8'd0, 8'd0};
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
      .fifo_rd_en(fifo_rd_en[0]), .tx_en(tx_en[0]), .tx(tx[0]), .busy(busy[0]),
      .frame_done(frame_done[0]), .frames_sent(frames_sent[0]));

   fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
      .fifo_rd_en(fifo_rd_en[1]), .tx_en(tx_en[1]), .tx(tx[1]), .busy(busy[1]),
      .frame_done(frame_done[1]), .frames_sent(frames_sent[1]));

   // synchronous FIFO model: registered data and empty flag
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (fifo_rd_en[i] === 1'b1) begin
            rd_cnt[i]++;
            if (frd[i] == fwr[i]) rd_viol[i]++;
            else begin
               fifo_data[i] <= fmem[i][frd[i]];
               frd[i] = frd[i] + 8'd1;
            end
         end
         fifo_empty[i] <= (frd[i] == fwr[i]);
      end
   end

   function automatic void check(input bit cond, input string name, input int act, input int req);
      n_checks++;
      if (cond) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endfunction

   // line receiver per DUT; every cycle of a frame is compared with the expected bit
   for (genvar gi = 0; gi < 2; gi++) begin : g_mon
      localparam int NB = (gi == 0) ? 10 : 12;
      logic [7:0]  exp_rd = 8'd0;
      int          nframes = 0;
      int          starts[$];
      logic [11:0] bits, rx;
      logic [7:0]  d;
      bit          ok, fd_ok, aborted;

      initial begin
         forever begin
            @(negedge clk);
            if (rst) nframes = 0;
            else if (tx[gi] === 1'b0) begin
               starts.push_back(cyc);
               d = 8'h00;
               if (exp_rd == ewr[gi]) check(1'b0, "unexpected_frame", gi, -1);
               else begin
                  d = exp_mem[gi][exp_rd];
                  exp_rd = exp_rd + 8'd1;
               end
               bits = '1;
               bits[0] = 1'b0;
               for (int k = 0; k < 8; k++) bits[1 + k] = d[k];
               if (gi == 1) bits[9] = ^d;
               rx = '1;
               ok = 1'b1; fd_ok = 1'b1; aborted = 1'b0;
               for (int c = 0; c < NB * 4; c++) begin
                  if (c > 0) @(negedge clk);
                  if (rst) begin aborted = 1'b1; break; end
                  if (c % 4 == 1) rx[c / 4] = tx[gi];
                  if (tx[gi] !== bits[c / 4]) ok = 1'b0;
                  if (frame_done[gi] !== (c == NB * 4 - 1)) fd_ok = 1'b0;
               end
               if (aborted) nframes = 0;
               else begin
                  nframes++;
                  check(ok, $sformatf("frame_bits%0d", gi), int'(rx), int'(bits));
                  check(fd_ok, $sformatf("frame_done%0d", gi), int'(fd_ok), 1);
                  @(negedge clk);
                  check(frames_sent[gi] == 16'(nframes), $sformatf("frames_sent%0d", gi),
                        int'(frames_sent[gi]), nframes);
               end
            end
         end
      end
   end

   task automatic push(input int i, input logic [7:0] b);
      fmem[i][fwr[i]]   = b;
      fwr[i]            = fwr[i] + 8'd1;
      exp_mem[i][ewr[i]] = b;
      ewr[i]            = ewr[i] + 8'd1;
   endtask

   task automatic wait_start(input int i, input int budget, input string name);
      int n = 0;
      while (tx[i] !== 1'b0 && n < budget) begin @(negedge clk); n++; end
      if (n >= budget) check(1'b0, name, n, budget);
   endtask

   task automatic wait_idle(input int i, input bit drain, input int budget, input string name);
      int n = 0;
      while ((busy[i] || (drain && frd[i] != fwr[i])) && n < budget) begin
         @(negedge clk); n++;
      end
      if (n >= budget) check(1'b0, name, n, budget);
      repeat (3) @(negedge clk);
   endtask

   int rd0;

   initial begin
      repeat (3) @(negedge clk);
      check(tx[0] == 1'b1, "rst_tx", tx[0], 1);
      check(busy[0] == 1'b0, "rst_busy", busy[0], 0);
      check(fifo_rd_en[0] == 1'b0, "rst_rd_en", fifo_rd_en[0], 0);
      check(frames_sent[0] == 16'd0, "rst_frames", frames_sent[0], 0);
      rst = 1'b0;
      tx_en[0] = 1'b1;
      tx_en[1] = 1'b1;

      // idle with empty FIFO
      repeat (100) @(negedge clk);
      check(rd_cnt[0] == 0, "idle_no_read", rd_cnt[0], 0);
      check(tx[0] == 1'b1 && busy[0] == 1'b0, "idle_line", {busy[0], tx[0]}, 1);

      // single byte
      push(0, 8'hA5);
      wait_idle(0, 1'b1, 200, "timeout_a5");
      check(rd_cnt[0] == 1, "a5_reads", rd_cnt[0], 1);
      check(frames_sent[0] == 16'd1, "a5_count", frames_sent[0], 1);

      // back-to-back spacing
      g_mon[0].starts.delete();
      push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
      wait_idle(0, 1'b1, 400, "timeout_b2b");
      check(g_mon[0].starts.size() == 3, "b2b_frames", g_mon[0].starts.size(), 3);
      if (g_mon[0].starts.size() == 3) begin
         check(g_mon[0].starts[1] - g_mon[0].starts[0] == 43, "b2b_gap1",
               g_mon[0].starts[1] - g_mon[0].starts[0], 43);
         check(g_mon[0].starts[2] - g_mon[0].starts[1] == 43, "b2b_gap2",
               g_mon[0].starts[2] - g_mon[0].starts[1], 43);
      end
      check(frames_sent[0] == 16'd4, "b2b_count", frames_sent[0], 4);

      // parity + two stop bits
      push(1, 8'h07);
      wait_idle(1, 1'b1, 200, "timeout_par");
      check(frames_sent[1] == 16'd1, "par_count", frames_sent[1], 1);

      // tx_en dropped mid-frame
      rd0 = rd_cnt[0];
      push(0, 8'h3C); push(0, 8'h55);
      wait_start(0, 50, "timeout_3c_start");
      repeat (12) @(negedge clk);
      tx_en[0] = 1'b0;
      wait_idle(0, 1'b0, 200, "timeout_3c");
      repeat (60) @(negedge clk);
      check(rd_cnt[0] == rd0 + 1, "txen_hold_reads", rd_cnt[0] - rd0, 1);
      check(busy[0] == 1'b0 && tx[0] == 1'b1, "txen_hold_idle", {busy[0], tx[0]}, 1);
      tx_en[0] = 1'b1;
      wait_idle(0, 1'b1, 200, "timeout_55");
      check(rd_cnt[0] == rd0 + 2, "txen_resume_reads", rd_cnt[0] - rd0, 2);

      // reset during D3 of 0xF0 (D3 = 0, so the line must jump high)
      rd0 = rd_cnt[0];
      push(0, 8'hF0); push(0, 8'h96);
      wait_start(0, 50, "timeout_f0_start");
      repeat (17) @(negedge clk);
      check(tx[0] == 1'b0, "d3_low", tx[0], 0);
      #2 rst = 1'b1;
      #1;
      check(tx[0] == 1'b1, "async_rst_tx", tx[0], 1);
      check(busy[0] == 1'b0, "async_rst_busy", busy[0], 0);
      check(frames_sent[0] == 16'd0, "async_rst_count", frames_sent[0], 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      wait_idle(0, 1'b1, 200, "timeout_96");
      check(frames_sent[0] == 16'd1, "post_rst_count", frames_sent[0], 1);
      check(rd_cnt[0] == rd0 + 2, "post_rst_reads", rd_cnt[0] - rd0, 2);

      // randomized traffic on both channels
      for (int k = 0; k < 30; k++) begin
         push(int'($urandom_range(0, 1)), 8'($urandom));
         tx_en[0] = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(0, 60)) @(negedge clk);
      end
      tx_en[0] = 1'b1;
      wait_idle(0, 1'b1, 3000, "timeout_rand0");
      wait_idle(1, 1'b1, 3000, "timeout_rand1");
      check(g_mon[0].exp_rd == ewr[0], "rand_drained0", g_mon[0].exp_rd, ewr[0]);
      check(g_mon[1].exp_rd == ewr[1], "rand_drained1", g_mon[1].exp_rd, ewr[1]);
      check(rd_viol[0] == 0 && rd_viol[1] == 0, "read_while_empty", rd_viol[0] + rd_viol[1], 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
